sw_stream_cmd_rx: RTL
=====================

Name: sw_stream_cmd_rx

Overview:
FPGA-side receiver for the host-to-card command stream feeding one Smith-Waterman engine; one instance per input PicoStream.
- Accepts a 128-bit header word, then the number of 128-bit query words the header announces.
- Presents the decoded header to the engine as a config beat.
- Forwards each query word tagged with a running query ID. The ID is echoed in result bits [47:32].

Parameters:
- DATA_W, 128, stream word width (header and query words).
- QID_W, 16, query ID width.
- CNT_W, 32, width of the query-count field.

Ports:
- clk  in  1  stream clock.
- rst  in  1  asynchronous, active-high reset.
- s_in_valid  in  1  input stream word valid.
- s_in_rdy  out  1  input stream ready.
- s_in_data  in  128  input stream word.
- cfg_valid  out  1  decoded header valid.
- cfg_rdy  in  1  engine accepts header.
- cfg_threshold  out  32  header [31:0], score threshold.
- cfg_ref_addr  out  32  header [63:32], DRAM reference start address.
- cfg_num_q  out  32  header [95:64], query count.
- cfg_ref_len  out  32  header [127:96], reference length, opaque to this block.
- q_valid  out  1  query word valid.
- q_rdy  in  1  engine accepts query word.
- q_data  out  128  query sequence word.
- q_id  out  16  ID of the query on q_data.
- q_last  out  1  last query of the current command.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clocking and reset: single clock, asynchronous active-high reset.
- Reset values: all outputs 0; state=IDLE; qid_ctr=0; remaining=0; cfg_* fields=0.
- Handshakes: a transfer occurs on valid&rdy at a rising edge. A valid, once asserted, holds its data stable until accepted.
- IDLE:
  - s_in_rdy=1.
  - On accept: latch all four fields and load remaining=[95:64].
  - Next state is CFG, with cfg_valid=1 registered, so it asserts one cycle after the header is accepted.
- CFG:
  - s_in_rdy=0; cfg_valid stays high until cfg_rdy.
  - On cfg accept with remaining==0: go to IDLE (empty command, no query beats).
  - On cfg accept otherwise: go to QUERY.
- QUERY, one-entry output register:
  - s_in_rdy = !q_valid | q_rdy, so back-to-back transfers sustain one word per cycle.
  - On input accept: q_data<=s_in_data, q_id<=qid_ctr, q_last<=(remaining==1), q_valid<=1; qid_ctr++ (wraps 0xFFFF->0); remaining--.
  - When q_valid&q_rdy with no new input: q_valid<=0.
  - After the beat with remaining==1 is accepted on input, s_in_rdy=0 and state becomes DRAIN.
- DRAIN:
  - s_in_rdy=0.
  - When the last q beat is accepted (q_valid&q_rdy&q_last): go to IDLE, q_valid<=0.
  - The next header cannot be accepted before this cycle. s_in_rdy=1 in IDLE on the following cycle.
- Latency: input word to q_valid is 1 cycle. Header to cfg_valid is 1 cycle.
- qid_ctr is not cleared between commands; only reset clears it.
- busy=1 in CFG, QUERY and DRAIN.
- Reset mid-operation: immediate return to IDLE. Any pending cfg or q beat is dropped and qid_ctr=0.
- Simultaneous q accept and input accept in QUERY: register reloads with the new word and q_valid stays 1.
- Full 32-bit remaining counter: counts above 2^16 are legal; q_id wraps independently.

Decomposition:
- Package sw_stream_pkg holds:
  - header field offsets (THR_LSB=0, ADDR_LSB=32, NUMQ_LSB=64, RLEN_LSB=96, field width 32);
  - state enum {IDLE, CFG, QUERY, DRAIN};
  - DATA_W and QID_W defaults, shared with the result transmitter, which packs q_id at [47:32] and location at [31:0].
- Optional sub-module sw_stream_skid: the one-entry q output register with its ready logic. The remaining logic stays flat.

Test Plan:
1. Reset, then header 0x000000800000000100000000000000FF.
   - cfg_valid one cycle later with threshold=0xFF, ref_addr=0, num_q=1, ref_len=0x80.
   - Query 0xc8facaa7c280aa28a020aaaf89aae004 is then emitted with q_id=0, q_last=1, and the block returns to IDLE.
2. Header with num_q=3, queries A, B, C back-to-back, q_rdy=1.
   - q beats on three consecutive cycles with q_id 0,1,2 (continuing from any previous count); q_last only on C.
   - s_in_rdy never drops during the queries.
3. num_q=2, q_rdy held 0 for 5 cycles.
   - First word sits in q; s_in_rdy=0; second word is not accepted until q_rdy=1.
   - No data is lost or duplicated.
4. Header with num_q=0.
   - cfg beat is issued and accepted; no q beats; busy=0 the cycle after cfg accept.
   - An immediately following header is accepted.
5. Force qid_ctr to 0xFFFF, send num_q=2.
   - q_id values 0xFFFF, then 0x0000.
6. Assert rst while in QUERY with q_valid=1 and remaining=4.
   - Outputs are 0 asynchronously; after release, a new header gives q_id=0.

Source files
------------

// File: rtl/sw_stream_pkg.sv
// Shared definitions for the Smith-Waterman command receiver and result transmitter.
// Header layout, FSM states and default stream widths.
package sw_stream_pkg;

    localparam int unsigned DEF_DATA_W = 128;
    localparam int unsigned DEF_QID_W  = 16;
    localparam int unsigned DEF_CNT_W  = 32;

    // Header word field offsets; every field is FIELD_W bits wide
    localparam int unsigned FIELD_W  = 32;
    localparam int unsigned THR_LSB  = 0;
    localparam int unsigned ADDR_LSB = 32;
    localparam int unsigned NUMQ_LSB = 64;
    localparam int unsigned RLEN_LSB = 96;

    // Result word packing used by the transmitter side
    localparam int unsigned RES_LOC_LSB = 0;
    localparam int unsigned RES_QID_LSB = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CFG   = 2'd1,
        QUERY = 2'd2,
        DRAIN = 2'd3
    } rx_state_t;

endpackage

// File: rtl/sw_stream_skid.sv
// One-entry output register for query beats; accepts a new beat whenever it is
// empty or being drained in the same cycle.
module sw_stream_skid
    import sw_stream_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned QID_W  = DEF_QID_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] in_data,
    input  logic [QID_W-1:0]  in_id,
    input  logic              in_last,
    output logic              in_rdy_c,
    input  logic              out_rdy,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [QID_W-1:0]  out_id,
    output logic              out_last
);

    assign in_rdy_c = !out_valid || out_rdy;

    // A load wins over a drain so back-to-back beats keep out_valid high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_id    <= in_id;
            out_last  <= in_last;
        end else if (out_valid && out_rdy) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sw_stream_cmd_rx.sv
// Host-to-card command stream receiver: decodes one header into a config beat,
// then forwards the announced number of query words tagged with a running ID.
module sw_stream_cmd_rx
    import sw_stream_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned QID_W  = DEF_QID_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_in_valid,
    output logic               s_in_rdy,
    input  logic [DATA_W-1:0]  s_in_data,
    output logic               cfg_valid,
    input  logic               cfg_rdy,
    output logic [FIELD_W-1:0] cfg_threshold,
    output logic [FIELD_W-1:0] cfg_ref_addr,
    output logic [CNT_W-1:0]   cfg_num_q,
    output logic [FIELD_W-1:0] cfg_ref_len,
    output logic               q_valid,
    input  logic               q_rdy,
    output logic [DATA_W-1:0]  q_data,
    output logic [QID_W-1:0]   q_id,
    output logic               q_last,
    output logic               busy
);

    rx_state_t        state;
    logic [CNT_W-1:0] remaining;
    logic [QID_W-1:0] qid_ctr;
    logic             skid_rdy;
    logic             in_acc;
    logic             q_load;

    // Input ready depends on state; held low while reset is asserted
    always_comb begin
        s_in_rdy = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    s_in_rdy = 1'b1;
                QUERY:   s_in_rdy = skid_rdy;
                default: s_in_rdy = 1'b0;
            endcase
        end
    end

    assign in_acc = s_in_valid && s_in_rdy;
    assign q_load = in_acc && (state == QUERY);
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cfg_valid     <= 1'b0;
            cfg_threshold <= '0;
            cfg_ref_addr  <= '0;
            cfg_num_q     <= '0;
            cfg_ref_len   <= '0;
            remaining     <= '0;
            qid_ctr       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_acc) begin
                        cfg_threshold <= s_in_data[THR_LSB +: FIELD_W];
                        cfg_ref_addr  <= s_in_data[ADDR_LSB +: FIELD_W];
                        cfg_num_q     <= s_in_data[NUMQ_LSB +: CNT_W];
                        cfg_ref_len   <= s_in_data[RLEN_LSB +: FIELD_W];
                        remaining     <= s_in_data[NUMQ_LSB +: CNT_W];
                        cfg_valid     <= 1'b1;
                        state         <= CFG;
                    end
                end
                CFG: begin
                    // An empty command skips straight back to IDLE
                    if (cfg_rdy) begin
                        cfg_valid <= 1'b0;
                        state     <= (remaining == '0) ? IDLE : QUERY;
                    end
                end
                QUERY: begin
                    if (in_acc) begin
                        qid_ctr   <= qid_ctr + QID_W'(1);
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (q_valid && q_rdy && q_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sw_stream_skid #(
        .DATA_W (DATA_W),
        .QID_W  (QID_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (q_load),
        .in_data   (s_in_data),
        .in_id     (qid_ctr),
        .in_last   (remaining == CNT_W'(1)),
        .in_rdy_c  (skid_rdy),
        .out_rdy   (q_rdy),
        .out_valid (q_valid),
        .out_data  (q_data),
        .out_id    (q_id),
        .out_last  (q_last)
    );

endmodule
